// File: rtl/tag_free_list.sv
// Free-list allocator for rename tags: a circular FIFO of free tag values plus
// an in-flight bitmap that rejects frees of tags that were never handed out.
module tag_free_list #(
  parameter int W_TAG        = 6,
  parameter bit INCLUDE_OREG = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_ren,
  output logic             alloc_valid,
  output logic [W_TAG-1:0] alloc_tag,
  input  logic             free_wen,
  input  logic [W_TAG-1:0] free_tag,
  output logic [W_TAG:0]   count,
  output logic             err_underflow,
  output logic             err_bad_free
);

  localparam int N_TAG = 2 ** W_TAG;

  // Handshake: a pop happens on a cycle where alloc_ren && alloc_valid; a push
  // happens on a cycle where free_wen is high and free_tag is currently in flight.
  logic [W_TAG-1:0] mem [N_TAG];
  logic [W_TAG-1:0] head;
  logic [W_TAG-1:0] tail;
  logic [W_TAG:0]   count_q;
  logic [W_TAG:0]   count_n;
  logic [N_TAG-1:0] inflight;
  logic             err_underflow_q;
  logic             err_bad_free_q;

  logic             avail;
  logic [W_TAG-1:0] head_tag;
  logic             pop_ok;
  logic             push_ok;

  assign avail    = (count_q != '0);
  assign head_tag = mem[head];
  assign pop_ok   = alloc_ren && avail;
  assign push_ok  = free_wen && inflight[free_tag];

  always_comb begin
    count_n = count_q + (W_TAG+1)'(push_ok) - (W_TAG+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_TAG; i++) mem[i] <= W_TAG'(i);
      head            <= '0;
      tail            <= '0;
      count_q         <= (W_TAG+1)'(N_TAG);
      inflight        <= '0;
      err_underflow_q <= 1'b0;
      err_bad_free_q  <= 1'b0;
    end else if (flush) begin
      // Restores every tag; error flags keep their history across a mispredict.
      for (int i = 0; i < N_TAG; i++) mem[i] <= W_TAG'(i);
      head     <= '0;
      tail     <= '0;
      count_q  <= (W_TAG+1)'(N_TAG);
      inflight <= '0;
    end else begin
      if (pop_ok) begin
        head               <= head + 1'b1;
        inflight[head_tag] <= 1'b1;
      end
      // The popped tag was not in flight, so it can never equal an accepted free_tag.
      if (push_ok) begin
        mem[tail]          <= free_tag;
        tail               <= tail + 1'b1;
        inflight[free_tag] <= 1'b0;
      end
      count_q <= count_n;
      if (alloc_ren && !avail) err_underflow_q <= 1'b1;
      if (free_wen && !inflight[free_tag]) err_bad_free_q <= 1'b1;
    end
  end

  generate
    if (INCLUDE_OREG) begin : g_oreg
      logic [W_TAG-1:0] head_n;
      logic [W_TAG-1:0] tag_n;
      logic             valid_q;
      logic [W_TAG-1:0] tag_q;

      // When the list drains to the pushed tag alone, head_n lands on the
      // slot being written this cycle, so forward the incoming value.
      always_comb begin
        head_n = head + W_TAG'(pop_ok);
        tag_n  = (push_ok && (tail == head_n)) ? free_tag : mem[head_n];
      end

      always_ff @(posedge clk) begin
        if (!reset || flush) begin
          valid_q <= 1'b1;
          tag_q   <= '0;
        end else begin
          valid_q <= (count_n != '0);
          tag_q   <= tag_n;
        end
      end

      assign alloc_valid = valid_q && reset;
      assign alloc_tag   = tag_q;
    end else begin : g_comb
      assign alloc_valid = avail && reset;
      assign alloc_tag   = head_tag;
    end
  endgenerate

  assign count         = count_q;
  assign err_underflow = err_underflow_q;
  assign err_bad_free  = err_bad_free_q;

endmodule

// File: tb/tb_tag_free_list.sv
// Directed bench for tag_free_list (W_TAG=3, combinational outputs): driver
// tasks queue the expected pop response, a negedge monitor checks it.
module tb_tag_free_list;

  localparam int W = 3;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         alloc_ren;
  logic         alloc_valid;
  logic [W-1:0] alloc_tag;
  logic         free_wen;
  logic [W-1:0] free_tag;
  logic [W:0]   count;
  logic         err_underflow;
  logic         err_bad_free;

  // Each entry: {expected alloc_valid, expected alloc_tag} for one alloc_ren cycle.
  logic [W:0] exp_q[$];
  int n_cmp;
  int n_bad;

  tag_free_list #(.W_TAG(W), .INCLUDE_OREG(1'b0)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .alloc_ren     (alloc_ren),
    .alloc_valid   (alloc_valid),
    .alloc_tag     (alloc_tag),
    .free_wen      (free_wen),
    .free_tag      (free_tag),
    .count         (count),
    .err_underflow (err_underflow),
    .err_bad_free  (err_bad_free)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: applies one cycle of inputs just after the active edge.
  task automatic drive(input logic fl, input logic ren, input logic fw,
                       input logic [W-1:0] ft, input logic ev, input logic [W-1:0] et);
    @(posedge clk);
    #1;
    flush     = fl;
    alloc_ren = ren;
    free_wen  = fw;
    free_tag  = ft;
    if (ren) exp_q.push_back({ev, et});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic pop(input logic [W-1:0] et);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b1, et);
  endtask

  task automatic free(input logic [W-1:0] ft);
    drive(1'b0, 1'b0, 1'b1, ft, 1'b0, '0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset && alloc_ren) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_cycle", 1, 0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("pop_valid", int'(alloc_valid), int'(e[W]));
        if (e[W]) chk("pop_tag", int'(alloc_tag), int'(e[W-1:0]));
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    alloc_ren = 1'b0;
    free_wen  = 1'b0;
    free_tag  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("valid_in_reset", int'(alloc_valid), 0);
    reset = 1'b1;
    #1;
    chk("rst_valid", int'(alloc_valid), 1);
    chk("rst_tag", int'(alloc_tag), 0);
    chk("rst_count", int'(count), 8);
    chk("rst_err_uf", int'(err_underflow), 0);
    chk("rst_err_bf", int'(err_bad_free), 0);

    // Drain all eight tags in order.
    for (int i = 0; i < 8; i++) begin
      pop(W'(i));
      chk("drain_count", int'(count), 8 - i);
    end
    idle();
    chk("drained_count", int'(count), 0);
    chk("drained_valid", int'(alloc_valid), 0);

    // Return 5 then 2; they reissue in return order.
    free(3'd5);
    free(3'd2);
    idle();
    chk("two_free_count", int'(count), 2);
    pop(3'd5);
    pop(3'd2);
    idle();
    chk("reissue_count", int'(count), 0);
    chk("no_err_yet", int'(err_underflow), 0);

    // Empty list: pop denied, simultaneous push of 3 accepted.
    drive(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, '0);
    idle();
    chk("uf_flag", int'(err_underflow), 1);
    chk("uf_count", int'(count), 1);
    chk("uf_valid", int'(alloc_valid), 1);
    chk("uf_tag", int'(alloc_tag), 3);

    // Flush restores; then pop four and flush again with alloc_ren high.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    idle();
    chk("flush_count", int'(count), 8);
    chk("flush_keeps_uf", int'(err_underflow), 1);
    for (int i = 0; i < 4; i++) pop(W'(i));
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 3'd4);
    idle();
    chk("flush2_count", int'(count), 8);
    chk("flush2_tag", int'(alloc_tag), 0);
    chk("flush2_uf", int'(err_underflow), 1);
    chk("flush2_bf", int'(err_bad_free), 0);
    free(3'd1);
    idle();
    chk("post_flush_bad_free", int'(err_bad_free), 1);
    chk("post_flush_count", int'(count), 8);

    // Reset clears sticky flags; then double free of tag 0.
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst2_uf", int'(err_underflow), 0);
    chk("rst2_bf", int'(err_bad_free), 0);
    pop(3'd0);
    free(3'd0);
    idle();
    chk("first_free_ok", int'(err_bad_free), 0);
    chk("first_free_count", int'(count), 8);
    free(3'd0);
    idle();
    chk("double_free_flag", int'(err_bad_free), 1);
    chk("double_free_count", int'(count), 8);

    // List order is now 1..7,0. Pop four to reach steady state at count 4.
    for (int i = 1; i <= 4; i++) pop(W'(i));
    idle();
    chk("steady_start_count", int'(count), 4);
    // Cycle k pops (5+k)%8 and returns the oldest in-flight tag (1+k)%8.
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 1'b1, W'((1 + k) % 8), 1'b1, W'((5 + k) % 8));
      chk("steady_count", int'(count), 4);
    end
    idle();
    chk("steady_end_count", int'(count), 4);
    chk("steady_end_tag", int'(alloc_tag), 1);
    chk("steady_no_uf", int'(err_underflow), 0);

    idle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tag_free_list.md
Name: tag_free_list

Overview:
- Free-list allocator for the rename tags stored in the register status table.
- Hands free tags to dispatch and reclaims them when the common data bus retires a result.
- A flush restores all tags after a mispredict.
- Circular FIFO of tag values plus an in-flight bitmap that detects illegal frees; it sits beside the RST on the dispatch and CDB paths.

Parameters:
W_TAG, 6, tag width; N_TAG = 2**W_TAG tags managed.
INCLUDE_OREG, 0, 1 = alloc_tag/alloc_valid registered (pop result visible one cycle later); 0 = combinational from head.

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low reset (reset==0 resets on posedge clk)
flush  input  1  synchronous restore of all tags to free
alloc_ren  input  1  dispatch consumes alloc_tag this cycle
alloc_valid  output  1  a free tag is available
alloc_tag  output  W_TAG  tag at FIFO head
free_wen  input  1  return free_tag to the list
free_tag  input  W_TAG  tag being retired
count  output  W_TAG+1  number of free tags, 0..N_TAG
err_underflow  output  1  sticky: alloc_ren while !alloc_valid
err_bad_free  output  1  sticky: free of a tag not in flight

Behaviour:
- Storage: mem[N_TAG] of W_TAG bits; head, tail pointers W_TAG bits, wrap modulo N_TAG; count W_TAG+1 bits; inflight[N_TAG] bitmap.
- Reset (reset==0 at posedge):
  - mem[i]=i, head=0, tail=0, count=N_TAG, inflight all 0, both error flags 0.
  - alloc_valid forced 0 while reset==0.
  - After release: alloc_valid=1, alloc_tag=0, count=N_TAG.
- Flush: same state as reset except error flags hold their value. Flush wins over alloc_ren and free_wen in the same cycle.
- alloc_valid = (count!=0).
  - INCLUDE_OREG=0: alloc_tag = mem[head], zero latency.
  - INCLUDE_OREG=1: both outputs registered from next-state; reset value 0 for alloc_tag and 1 after reset release.
- Pop: alloc_ren && alloc_valid → head<=head+1, inflight[alloc_tag]<=1.
  - alloc_ren && !alloc_valid → no state change; err_underflow<=1.
- Push: free_wen && inflight[free_tag] → mem[tail]<=free_tag, tail<=tail+1, inflight[free_tag]<=0.
  - free_wen && !inflight[free_tag] (double free or never allocated) → dropped; err_bad_free<=1.
  - Full can only arise with inflight all 0, so this check also prevents overflow.
- Simultaneous legal pop and push: both occur, count unchanged.
  - A freed tag is not bypassed to alloc_tag in the same cycle; it is visible only once it reaches head.
  - count==0 with a simultaneous push → pop denied (err_underflow set if alloc_ren); push accepted; count becomes 1.
- Same tag popped and freed in the same cycle is impossible, since the popped tag was not in flight; the free of that tag is flagged bad and the pop proceeds.
- count next = count + push_ok − pop_ok; never exceeds N_TAG, never below 0.
- Pointer wrap: after N_TAG pops head returns to 0; order of reissue equals order of return.
- Error flags are sticky and are cleared only by reset.

Test Plan:
- W_TAG=3. Release reset, pop 8 consecutive cycles → alloc_tag 0,1,…,7; count 8→0; alloc_valid=0 after the 8th pop.
- After the previous test, free tags 5,2 in order, then pop twice → alloc_tag 5 then 2; count 0→2→0.
- count=0, alloc_ren=1 and free_wen=1 with tag 3 same cycle → no pop, err_underflow=1, count=1, next cycle alloc_tag=3.
- Pop tag 0, free 0, free 0 again → second free dropped, err_bad_free=1, count returns to 8 not 9.
- Pop 4 tags, pulse flush with alloc_ren=1 → count=8, alloc_tag=0, inflight cleared; err flags unchanged; a later free of 1 sets err_bad_free.
- Steady state with count=4: pop and free every cycle for 20 cycles → count stays 4, head/tail wrap correctly, tags reissued in FIFO order.
